// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared encodings for the multicycle RV32I sequencing controller:
//   - state_t      : FSM state enumeration (4-bit)
//   - ALUOP_*      : ALU operation class passed from the FSM to the ALU decoder
//   - ALUC_*       : ALUControl codes understood by the datapath ALU
//   - OP_*         : supported RV32I opcodes
//   - RES_* / SRCA_* / SRCB_* / IMM_* : datapath mux select encodings
//   - imm_src_of() : immediate format select derived from the opcode
// -----------------------------------------------------------------------------
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format for an opcode; unsupported opcodes fall back to I-type.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    imm = IMM_I;
    case (op)
      OP_LOAD,
      OP_ITYPE:  imm = IMM_I;
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the sequencing controller and the multicycle datapath.
//   Datapath -> controller : op, funct3, funct7, zero, mem_ready
//   Controller -> datapath : PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//                            ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl,
//                            instr_done, illegal_op
// modport master : the controller side (drives the enables and selects)
// modport slave  : the datapath side (drives the instruction fields and flags)
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, instr_done, illegal_op
  );

  modport slave (
    output op, funct3, funct7, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, instr_done, illegal_op
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU decoder, shared with the single-cycle core.
//   alu_op      in  2 : operation class from the main controller
//   funct3      in  3 : IR[14:12]
//   funct7      in  1 : IR[30]
//   op5         in  1 : IR[5], distinguishes R-type (1) from I-type (0)
//   alu_control out 3 : ALU function select
// -----------------------------------------------------------------------------
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // IR[30] only means subtract for R-type; addi may carry any
          // immediate bit there.
          3'b000:  alu_control = ({op5, funct7} == 2'b11) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_control = ALUC_SLT;
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore sequencing controller for the multicycle RV32I core. Steps the shared
// ALU, single memory port, IR and register file through fetch / decode /
// execute / memory / writeback for lw, sw, R-type, I-type ALU, beq and jal.
//   clk   in : rising-edge clock
//   reset in : asynchronous active-high reset, forces IDLE
//   bus      : multicycle_ctrl_if.master (instruction fields and flags in,
//              datapath enables and selects out)
// The state register is the only storage; every output is combinational.
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t     state_reg;
  state_t     state_next;

  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    alu_op         = ALUOP_ADD;
    branch         = 1'b0;
    pc_update      = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RD2;
    bus.RegWrite   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    // The immediate extender follows the opcode everywhere except IDLE,
    // where everything is held at zero.
    bus.ImmSrc     = (state_reg == S_IDLE) ? IMM_I : imm_src_of(bus.op);

    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
      end

      // Instruction read through the shared port; PC+4 is computed in
      // parallel and written only when the access completes.
      S_FETCH: begin
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        alu_op        = ALUOP_ADD;
        bus.ResultSrc = RES_ALURESULT;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          pc_update   = 1'b1;
          state_next  = S_DECODE;
        end
      end

      // OldPC + ImmExt lands in ALUOut, ready as the branch target.
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_ADD;
        case (bus.op)
          OP_LOAD,
          OP_STORE:  state_next = S_MEMADR;
          OP_RTYPE:  state_next = S_EXECUTER;
          OP_ITYPE:  state_next = S_EXECUTEI;
          OP_BRANCH: state_next = S_BEQ;
          OP_JAL:    state_next = S_JAL;
          default: begin
            bus.illegal_op = 1'b1;
            state_next     = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_ADD;
        // op[5] separates store (0100011) from load (0000011).
        state_next  = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
        if (bus.mem_ready) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        bus.ResultSrc  = RES_DATA;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end

      // The write strobe stays high until the memory accepts it.
      S_MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
        bus.MemWrite  = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_next     = S_FETCH;
        end
      end

      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_RD2;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end

      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end

      S_ALUWB: begin
        bus.ResultSrc  = RES_ALUOUT;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end

      // RD1 - RD2 sets zero; ALUOut still holds the target from DECODE.
      S_BEQ: begin
        bus.ALUSrcA    = SRCA_RD1;
        bus.ALUSrcB    = SRCB_RD2;
        alu_op         = ALUOP_SUB;
        bus.ResultSrc  = RES_ALUOUT;
        branch         = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end

      // PC takes the target in ALUOut while the ALU forms OldPC + 4, which
      // ALUWB then writes to rd.
      S_JAL: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        alu_op        = ALUOP_ADD;
        bus.ResultSrc = RES_ALUOUT;
        pc_update     = 1'b1;
        state_next    = S_ALUWB;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.PCWrite = (branch & bus.zero) | pc_update;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7      (bus.funct7),
    .op5         (bus.op[5]),
    .alu_control (bus.ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed stimulus for multicycle_ctrl. Each driven cycle pushes the
// hand-derived control vector for that cycle; each started instruction pushes
// its expected FETCH-to-FETCH length. A monitor on the falling edge pops and
// compares both.
// Vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//                 ALUSrcB, ImmSrc, RegWrite, ALUControl, instr_done, illegal_op}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;
  localparam logic [17:0] ZERO_V = 18'd0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [17:0] act;
  assign act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                bus.RegWrite, bus.ALUControl, bus.instr_done, bus.illegal_op};

  logic [17:0] exp_q[$];
  string       name_q[$];
  int          lat_q[$];
  string       lat_name_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        end_req = 1'b0;

  function automatic logic [17:0] vec(input logic pcw, input logic adr,
                                      input logic mw, input logic irw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] imm,
                                      input logic rw, input logic [2:0] alu,
                                      input logic done, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, done, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic [1:0] imm, input logic mr);
    return vec(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, imm, 1'b0, 3'b000, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] decode_v(input logic [1:0] imm, input logic ill);
    return vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 1'b0, 3'b000, 1'b0, ill);
  endfunction

  function automatic logic [17:0] aluwb_v(input logic [1:0] imm);
    return vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b1, 3'b000, 1'b1, 1'b0);
  endfunction

  task automatic step(input string nm, input logic rst, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic mr, input logic [17:0] e);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.op        = o;
    bus.funct3    = f3;
    bus.funct7    = f7;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_len(input string nm, input int n);
    lat_q.push_back(n);
    lat_name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  int          cyc_cnt = 0;
  always @(negedge clk) begin : monitor
    logic [17:0] e;
    string       nm;
    int          l;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got=%b want=%b", nm, act, e);
      end else begin
        $display("ok   %s: %b", nm, act);
      end
    end
    if (reset) begin
      cyc_cnt = 0;
    end else if (act != ZERO_V) begin
      cyc_cnt++;
      if (bus.instr_done || bus.illegal_op) begin
        checks++;
        if (lat_q.size() == 0) begin
          failures++;
          $display("FAIL len_unexpected: got=%0d cycles want=no completion", cyc_cnt);
        end else begin
          l  = lat_q.pop_front();
          nm = lat_name_q.pop_front();
          if (cyc_cnt != l) begin
            failures++;
            $display("FAIL len_%s: got=%0d cycles want=%0d", nm, cyc_cnt, l);
          end else begin
            $display("ok   len_%s: %0d cycles", nm, cyc_cnt);
          end
        end
        cyc_cnt = 0;
      end
    end
    if (end_req) begin
      checks++;
      if (lat_q.size() != 0) begin
        failures++;
        $display("FAIL len_pending: got=%0d outstanding want=0", lat_q.size());
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL vec_pending: got=%0d outstanding want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    reset         = 1'b1;
    bus.op        = LW;
    bus.funct3    = 3'b010;
    bus.funct7    = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    step("reset_held", 1, LW, 3'b010, 0, 0, 1, ZERO_V);
    step("idle",       0, LW, 3'b010, 0, 0, 1, ZERO_V);

    // lw, no stalls: 5 cycles
    expect_len("lw", 5);
    step("lw_fetch",   0, LW, 3'b010, 0, 0, 1, fetch_v(2'b00, 1'b1));
    step("lw_decode",  0, LW, 3'b010, 0, 0, 1, decode_v(2'b00, 1'b0));
    step("lw_memadr",  0, LW, 3'b010, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0,0));
    step("lw_memread", 0, LW, 3'b010, 0, 0, 1, vec(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0,0));
    step("lw_memwb",   0, LW, 3'b010, 0, 0, 1, vec(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000,1,0));

    // sw with two wait cycles in MEMWRITE: 6 cycles
    expect_len("sw_stall", 6);
    step("sw_fetch",   0, SW, 3'b010, 0, 0, 1, fetch_v(2'b01, 1'b1));
    step("sw_decode",  0, SW, 3'b010, 0, 0, 1, decode_v(2'b01, 1'b0));
    step("sw_memadr",  0, SW, 3'b010, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000,0,0));
    step("sw_wr_wait1",0, SW, 3'b010, 0, 0, 0, vec(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0,0));
    step("sw_wr_wait2",0, SW, 3'b010, 0, 0, 0, vec(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0,0));
    step("sw_wr_done", 0, SW, 3'b010, 0, 0, 1, vec(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,1,0));

    // R-type sub: 4 cycles
    expect_len("sub", 4);
    step("sub_fetch",  0, RT, 3'b000, 1, 0, 1, fetch_v(2'b00, 1'b1));
    step("sub_decode", 0, RT, 3'b000, 1, 0, 1, decode_v(2'b00, 1'b0));
    step("sub_exec",   0, RT, 3'b000, 1, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b001,0,0));
    step("sub_aluwb",  0, RT, 3'b000, 1, 0, 1, aluwb_v(2'b00));

    // addi with IR[30]=1 must still add
    expect_len("addi", 4);
    step("addi_fetch", 0, IT, 3'b000, 1, 0, 1, fetch_v(2'b00, 1'b1));
    step("addi_decode",0, IT, 3'b000, 1, 0, 1, decode_v(2'b00, 1'b0));
    step("addi_exec",  0, IT, 3'b000, 1, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0,0));
    step("addi_aluwb", 0, IT, 3'b000, 1, 0, 1, aluwb_v(2'b00));

    // R-type or with one fetch wait: 5 cycles
    expect_len("or_stall", 5);
    step("or_fetch_wait", 0, RT, 3'b110, 0, 0, 0, fetch_v(2'b00, 1'b0));
    step("or_fetch",   0, RT, 3'b110, 0, 0, 1, fetch_v(2'b00, 1'b1));
    step("or_decode",  0, RT, 3'b110, 0, 0, 1, decode_v(2'b00, 1'b0));
    step("or_exec",    0, RT, 3'b110, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b011,0,0));
    step("or_aluwb",   0, RT, 3'b110, 0, 0, 1, aluwb_v(2'b00));

    // slti and R-type and
    expect_len("slti", 4);
    step("slti_fetch", 0, IT, 3'b010, 0, 0, 1, fetch_v(2'b00, 1'b1));
    step("slti_decode",0, IT, 3'b010, 0, 0, 1, decode_v(2'b00, 1'b0));
    step("slti_exec",  0, IT, 3'b010, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b101,0,0));
    step("slti_aluwb", 0, IT, 3'b010, 0, 0, 1, aluwb_v(2'b00));
    expect_len("and", 4);
    step("and_fetch",  0, RT, 3'b111, 0, 0, 1, fetch_v(2'b00, 1'b1));
    step("and_decode", 0, RT, 3'b111, 0, 0, 1, decode_v(2'b00, 1'b0));
    step("and_exec",   0, RT, 3'b111, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b010,0,0));
    step("and_aluwb",  0, RT, 3'b111, 0, 0, 1, aluwb_v(2'b00));

    // beq taken (zero high throughout, only BEQ may use it), then not taken
    expect_len("beq_taken", 3);
    step("beqt_fetch", 0, BEQ, 3'b000, 0, 1, 1, fetch_v(2'b10, 1'b1));
    step("beqt_decode",0, BEQ, 3'b000, 0, 1, 1, decode_v(2'b10, 1'b0));
    step("beqt_beq",   0, BEQ, 3'b000, 0, 1, 1, vec(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,1,0));
    expect_len("beq_nottaken", 3);
    step("beqn_fetch", 0, BEQ, 3'b000, 0, 0, 1, fetch_v(2'b10, 1'b1));
    step("beqn_decode",0, BEQ, 3'b000, 0, 0, 1, decode_v(2'b10, 1'b0));
    step("beqn_beq",   0, BEQ, 3'b000, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,1,0));

    // jal: 4 cycles
    expect_len("jal", 4);
    step("jal_fetch",  0, JAL, 3'b000, 0, 0, 1, fetch_v(2'b11, 1'b1));
    step("jal_decode", 0, JAL, 3'b000, 0, 0, 1, decode_v(2'b11, 1'b0));
    step("jal_jal",    0, JAL, 3'b000, 0, 0, 1, vec(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,3'b000,0,0));
    step("jal_aluwb",  0, JAL, 3'b000, 0, 0, 1, aluwb_v(2'b11));

    // illegal opcode: 2 cycles
    expect_len("illegal", 2);
    step("ill_fetch",  0, BAD, 3'b000, 0, 0, 1, fetch_v(2'b00, 1'b1));
    step("ill_decode", 0, BAD, 3'b000, 0, 0, 1, decode_v(2'b00, 1'b1));

    // lw with one wait in MEMREAD: 6 cycles
    expect_len("lw_stall", 6);
    step("lws_fetch",  0, LW, 3'b010, 0, 0, 1, fetch_v(2'b00, 1'b1));
    step("lws_decode", 0, LW, 3'b010, 0, 0, 1, decode_v(2'b00, 1'b0));
    step("lws_memadr", 0, LW, 3'b010, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0,0));
    step("lws_rd_wait",0, LW, 3'b010, 0, 0, 0, vec(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0,0));
    step("lws_rd_done",0, LW, 3'b010, 0, 0, 1, vec(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0,0));
    step("lws_memwb",  0, LW, 3'b010, 0, 0, 1, vec(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000,1,0));

    // sw aborted by reset asserted mid-cycle while in MEMWRITE
    step("swr_fetch",  0, SW, 3'b010, 0, 0, 1, fetch_v(2'b01, 1'b1));
    step("swr_decode", 0, SW, 3'b010, 0, 0, 1, decode_v(2'b01, 1'b0));
    step("swr_memadr", 0, SW, 3'b010, 0, 0, 1, vec(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000,0,0));
    step("swr_wr_wait",0, SW, 3'b010, 0, 0, 0, vec(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0,0));
    step("swr_reset_in_wr", 1, SW, 3'b010, 0, 0, 0, ZERO_V);
    step("swr_reset_held",  1, SW, 3'b010, 0, 0, 0, ZERO_V);
    step("swr_idle",        0, SW, 3'b010, 0, 0, 0, ZERO_V);
    step("swr_refetch_wait",0, SW, 3'b010, 0, 0, 0, fetch_v(2'b01, 1'b0));

    @(posedge clk);
    #1;
    end_req = 1'b1;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle RV32I core: a Moore FSM that steps the shared ALU, memory port, instruction register and register file through fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal. It sits beside the datapath, reads the opcode and funct fields from the instruction register plus the ALU zero flag, and drives every datapath enable and mux select. A single memory port serves both instruction and data accesses, so the FSM stalls on `mem_ready`.

## Interface
- No parameters; all encodings are fixed in the shared package.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: opcode from IR.
- `funct3` in 3: IR[14:12].
- `funct7` in 1: IR[30].
- `zero` in 1: ALU result-is-zero flag.
- `mem_ready` in 1: memory completed the current access this cycle.
- `PCWrite` out 1: PC load, `(Branch & zero) | PCUpdate`.
- `AdrSrc` out 1: memory address select, 0 = PC, 1 = Result.
- `MemWrite` out 1: data memory write strobe.
- `IRWrite` out 1: loads IR and OldPC.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J.
- `RegWrite` out 1: register file write.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `instr_done` out 1: one-cycle pulse in the last state of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE on an unsupported opcode.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Reset forces IDLE. In IDLE all outputs are 0, and every select or ALUControl field is 000 or 00. IDLE always goes to FETCH.
- Unlisted signals in any state are 0.
- **FETCH**: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only when `mem_ready` = 1.
  - Stay in FETCH while `mem_ready` = 0; go to DECODE when it is 1.
- **DECODE**: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other → FETCH, with `illegal_op` = 1
- **MEMADR**: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op[5] = 0, otherwise MEMWRITE.
- **MEMREAD**: AdrSrc=1, ResultSrc=00. Stay while `mem_ready` = 0; go to MEMWB when it is 1.
- **MEMWB**: ResultSrc=01, RegWrite=1, `instr_done`. Goes to FETCH.
- **MEMWRITE**: AdrSrc=1, ResultSrc=00, MemWrite=1. Holds while `mem_ready` = 0, keeping MemWrite high. When `mem_ready` = 1: `instr_done`, then FETCH.
- **EXECUTER**: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- **EXECUTEI**: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1, `instr_done`. Goes to FETCH.
- **BEQ**: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, `instr_done`. Goes to FETCH.
- **JAL**: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB, which writes PC+4 to rd.
- **ImmSrc**: decoded from `op` in every state except IDLE.
  - lw, I-type → 00; sw → 01; beq → 10; jal → 11; else → 00.
- **ALU decoder**:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10 decodes funct3:
    - 000 → sub if {op[5], funct7} = 11, otherwise add
    - 010 → slt; 110 → or; 111 → and
    - other funct3 → add

## Timing
- State register is the only storage. All outputs are combinational from state, op, funct3, funct7, zero and mem_ready; there are no registered outputs.
- Latency in cycles from FETCH entry to next FETCH entry, with `mem_ready` tied high:
  - lw 5; sw 4; R-type 4; I-type 4; beq 3; jal 4; illegal 2.
- Each cycle with `mem_ready` = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- A reset assertion mid-instruction returns the FSM to IDLE immediately and drops all enables asynchronously.

## Structure
- Package `multicycle_pkg` holds:
  - the state enumeration (4-bit encoding)
  - the ALUOp constants
  - the ALUControl codes
  - the opcode constants
  - the ResultSrc, ALUSrcA and ALUSrcB encodings
- Sub-module `alu_decoder`: combinational ALUOp/funct3/funct7/op5 → ALUControl, reusable by the single-cycle core.

## Test plan
- Reset asserted, then released with `mem_ready` = 1 and op = 0000011 → cycle 0 IDLE with all outputs 0; cycle 1 FETCH with IRWrite = 1 and PCWrite = 1; `instr_done` in the 5th cycle after FETCH entry (MEMWB, RegWrite = 1, ResultSrc = 01).
- sw (0100011) with `mem_ready` low for 2 cycles in MEMWRITE → MemWrite held 3 cycles, AdrSrc = 1, ImmSrc = 01; `instr_done` only on the cycle `mem_ready` = 1.
- R-type sub (op = 0110011, funct3 = 000, funct7 = 1) → ALUControl = 001 in EXECUTER; the same encoding with op = 0010011 (addi, funct7 = 1) → ALUControl = 000.
- beq with zero = 1, then beq with zero = 0 → PCWrite = 1 in BEQ only in the first case; both take 3 cycles, and ImmSrc = 10.
- jal (1101111) → PCWrite = 1 in JAL with ALUSrcA = 01 and ALUSrcB = 10, then ALUWB with RegWrite = 1; ImmSrc = 11.
- op = 1111111 in DECODE → `illegal_op` pulse, no RegWrite or MemWrite, back to FETCH. Separately, reset asserted while in MEMWRITE → MemWrite = 0 in the same cycle and the FSM in IDLE.
